// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the frame-sum accumulator.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_IN_WIDTH    = 10;
    localparam int DEF_ACC_WIDTH   = 16;
    localparam int DEF_NUM_SAMPLES = 4;

endpackage

// File: rtl/sat_add.sv
// Signed accumulate step. Define SUM_ACC_SAT_EN to clamp on overflow and flag it;
// otherwise the sum wraps and o_sat is constant 0.
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum,
    output logic                o_sat
);

`ifdef SUM_ACC_SAT_EN
    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [W:0] w_wide;

    assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // Overflow shows up as disagreement between the guard bit and the result sign.
    always_comb begin
        o_sum = w_wide[W-1:0];
        o_sat = 1'b0;
        if (w_wide[W] != w_wide[W-1]) begin
            o_sat = 1'b1;
            o_sum = w_wide[W] ? MIN_VAL : MAX_VAL;
        end
    end
`else
    assign o_sum = i_a + i_b;
    assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Sums numSamples signed samples per frame and holds the result until taken.
// Overflow behaviour (wrap or clamp) is chosen inside sat_add by SUM_ACC_SAT_EN.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int inWidth    = DEF_IN_WIDTH,
    parameter int accWidth   = DEF_ACC_WIDTH,
    parameter int numSamples = DEF_NUM_SAMPLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [inWidth-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [accWidth-1:0] out_data,
    output logic                       out_sat,
    output logic                       busy
);

    localparam int             CNT_W    = $clog2(numSamples + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numSamples - 1);

    state_t                     r_state;
    logic signed [accWidth-1:0] r_acc;
    logic signed [accWidth-1:0] r_out_data;
    logic        [CNT_W-1:0]    r_count;
    logic                       r_sat;
    logic                       r_out_valid;
    logic                       r_in_ready;
    logic                       r_busy;

    logic signed [accWidth-1:0] w_in_ext;
    logic signed [accWidth-1:0] w_base;
    logic signed [accWidth-1:0] w_sum;
    logic                       w_sat;
    logic                       w_take;
    logic                       w_last;

    assign w_in_ext = accWidth'(in_data);
    // First sample of a frame loads rather than adds, so the adder sees zero.
    assign w_base   = (r_state == IDLE) ? '0 : r_acc;
    assign w_take   = in_valid && r_in_ready;
    assign w_last   = (r_count == LAST_CNT);

    sat_add #(
        .W(accWidth)
    ) u_add (
        .i_a  (w_base),
        .i_b  (w_in_ext),
        .o_sum(w_sum),
        .o_sat(w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_take) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + CNT_W'(1);
                        r_sat   <= r_sat | w_sat;
                        r_busy  <= 1'b1;
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sum;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Release frees the frame; ready returns only on the following cycle.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_sat       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_sat;
    assign busy      = r_busy;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter inWidth, default 10: width of the signed input sample, matching the adder's sum width.
REQ-002 The block SHALL have parameter accWidth, default 16: width of the signed accumulator and result; legal range accWidth >= inWidth.
REQ-003 The block SHALL have parameter numSamples, default 4: samples per frame; legal range numSamples >= 1.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 in_data  input  inWidth  signed sample from the upstream adder.
REQ-010 out_valid  output  1  frame result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  accWidth  signed frame sum.
REQ-013 out_sat  output  1  saturation occurred during the current frame.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The state machine SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 A sample transfer SHALL occur only when in_valid and in_ready are both high; in_data is ignored in every other cycle.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 A transfer in IDLE SHALL load acc = sign-extended in_data and set count = 1, then move to ACCUM, or to HOLD if numSamples == 1.
REQ-019 A transfer in ACCUM SHALL add the sign-extended in_data to acc and increment count; the transfer that makes count == numSamples SHALL move the state to HOLD.
REQ-020 out_valid SHALL be high exactly while in HOLD, i.e. from the cycle after the last sample transfer; that is one cycle of latency.
REQ-021 out_data and out_sat SHALL be held stable throughout HOLD.
REQ-022 In HOLD, out_ready = 1 SHALL move the state to IDLE at the next edge and clear acc, count and out_sat.
REQ-023 No sample SHALL be accepted in the cycle in which HOLD exits; minimum frame period is numSamples+1 cycles.
REQ-024 out_data SHALL be 0 whenever out_valid is 0.
REQ-025 The count register SHALL be $clog2(numSamples+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-026 rst SHALL force state IDLE, acc = 0, count = 0, out_valid = 0, out_data = 0, out_sat = 0 and busy = 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-027 rst asserted mid-frame or in HOLD SHALL discard the partial or held result with no output transfer.
REQ-028 rst SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-029 With macro SUM_ACC_SAT_EN defined, each addition SHALL be computed at accWidth+1 bits and clamped to [-2^(accWidth-1), 2^(accWidth-1)-1], and any clamp SHALL set out_sat sticky until the frame is released.
REQ-030 Without SUM_ACC_SAT_EN, the addition SHALL wrap modulo 2^accWidth and out_sat SHALL be tied to 0.

Structure
REQ-031 Package sum_acc_pkg SHALL hold the state enum typedef and the default width constants.
REQ-032 Sub-module sat_add (signed add with optional clamp, combinational) SHALL implement the accumulate step, and the SUM_ACC_SAT_EN conditional SHALL live only inside it.

Verification
REQ-033 With defaults, contiguous inputs 2, 4, 105, 100 and out_ready = 1 SHALL give out_data = 211 and out_sat = 0, with out_valid high for 1 cycle, one cycle after the 4th transfer.
REQ-034 Inputs -3, 7, -100, 5 SHALL give out_data = -91.
REQ-035 With out_ready held 0 for 5 cycles in HOLD, out_data SHALL stay stable and in_ready SHALL stay 0; one cycle after out_ready goes to 1, the state SHALL be IDLE.
REQ-036 With in_valid toggling every other cycle over inputs 1, 1, 1, 1, only the handshaked samples SHALL count, giving out_data = 4.
REQ-037 For an instance with accWidth = 10 and inputs 511 x4: with SUM_ACC_SAT_EN, out_data SHALL be 511 and out_sat = 1; without it, out_data SHALL be -4. For inputs -512 x4: with SUM_ACC_SAT_EN, out_data SHALL be -512; without it, out_data SHALL be 0.
REQ-038 rst asserted after 2 accepted samples SHALL zero all outputs, and a following frame of 1, 1, 1, 1 SHALL give out_data = 4.
